weight_load_sched: RTL and testbench

//  Sequences per-layer weight streams (64-bit beats, valid/last/ready) into a
//  two-bank ping-pong weight buffer feeding the conv engine. Loads cfg_tiles

---
 rtl/weight_sched_pkg.sv | 24 ++
 rtl/weight_load_sched_bank_tracker.sv | 38 +++
 rtl/weight_load_sched.sv | 204 ++++++++++++++++++++
 tb/tb_weight_load_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_sched_pkg.sv
// Shared types and defaults for the weight-load scheduler: FSM encoding,
// width defaults and the bank-select helper.
package weight_sched_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_LEN_W  = 11;
    localparam int DEF_TILE_W = 8;
    localparam int BANKS      = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BANK = 3'd1,
        ST_LOAD      = 3'd2,
        ST_COMMIT    = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } sched_state_e;

    function automatic logic [BANKS-1:0] bank_mask(input logic bank);
        bank_mask = bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/weight_load_sched_bank_tracker.sv
// Per-bank "holds a complete tile" flags. A set on a bank wins over a
// release of the same bank in the same cycle.
module bank_tracker
    import weight_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic             set_bank,
    input  logic [BANKS-1:0] release_mask,
    output logic [BANKS-1:0] full
);

    logic [BANKS-1:0] full_q;
    logic [BANKS-1:0] full_d;

    // Next flag state: drop released banks, then apply the set.
    always_comb begin
        full_d = full_q & ~release_mask;
        if (set_en) begin
            full_d = full_d | bank_mask(set_bank);
        end else begin
            full_d = full_d;
        end
    end

    // Flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= {BANKS{1'b0}};
        end else begin
            full_q <= full_d;
        end
    end

    assign full = full_q;

endmodule

// File: rtl/weight_load_sched.sv
// Streams cfg_tiles tiles of cfg_len weight beats into a ping-pong buffer,
// waiting for the engine to release a bank before refilling it.
module weight_load_sched
    import weight_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int TILE_W = DEF_TILE_W
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              cfg_start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [TILE_W-1:0] cfg_tiles,
    output logic              busy,
    output logic              done,
    output logic              err_last,
    input  logic [DATA_W-1:0] s_weight_data,
    input  logic              s_weight_valid,
    input  logic              s_weight_last,
    output logic              s_weight_ready,
    output logic              buf_wr_en,
    output logic              buf_wr_bank,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic [1:0]        bank_full,
    input  logic [1:0]        bank_release
);

    sched_state_e      state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              handshake;
    logic              final_beat;
    logic              commit_set;
    logic [TILE_W-1:0] tile_cnt_inc;
    logic [BANKS-1:0]  bank_full_s;

    assign handshake    = s_weight_valid & ready_q;
    assign final_beat   = (beat_cnt_q == (len_q - LEN_W'(1)));
    assign tile_cnt_inc = tile_cnt_q + TILE_W'(1);

    bank_tracker u_bank_tracker (
        .clk          (sclk),
        .rst          (s_rst),
        .set_en       (commit_set),
        .set_bank     (ptr_q),
        .release_mask (bank_release),
        .full         (bank_full_s)
    );

    // Sequencing FSM, counters, write pipeline and last-flag checker.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        tile_cnt_d = tile_cnt_q;
        tiles_d    = tiles_q;
        err_d      = err_q;
        wr_en_d    = 1'b0;
        wr_bank_d  = wr_bank_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        commit_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    len_d      = cfg_len;
                    tiles_d    = cfg_tiles;
                    err_d      = 1'b0;
                    beat_cnt_d = {LEN_W{1'b0}};
                    tile_cnt_d = {TILE_W{1'b0}};
                    // Both banks are empty after a completed layer, so every layer starts on bank 0.
                    ptr_d      = 1'b0;
                    if ((cfg_len == {LEN_W{1'b0}}) || (cfg_tiles == {TILE_W{1'b0}})) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_BANK;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_BANK: begin
                if (!bank_full_s[ptr_q]) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_WAIT_BANK;
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    wr_en_d    = 1'b1;
                    wr_bank_d  = ptr_q;
                    wr_addr_d  = beat_cnt_q[ADDR_W-1:0];
                    wr_data_d  = s_weight_data;
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    // Framing follows cfg_len; the source's last flag is only checked.
                    if (s_weight_last != final_beat) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (final_beat) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                commit_set = 1'b1;
                ptr_d      = ~ptr_q;
                tile_cnt_d = tile_cnt_inc;
                beat_cnt_d = {LEN_W{1'b0}};
                if (tile_cnt_inc == tiles_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT_BANK;
                end
            end
            ST_DRAIN: begin
                if (bank_full_s == 2'b00) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_LOAD);
        done_d  = (state_q == ST_DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            beat_cnt_q <= {LEN_W{1'b0}};
            len_q      <= {LEN_W{1'b0}};
            tile_cnt_q <= {TILE_W{1'b0}};
            tiles_q    <= {TILE_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_bank_q  <= 1'b0;
            wr_addr_q  <= {ADDR_W{1'b0}};
            wr_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            tile_cnt_q <= tile_cnt_d;
            tiles_q    <= tiles_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            wr_en_q    <= wr_en_d;
            wr_bank_q  <= wr_bank_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_last       = err_q;
    assign s_weight_ready = ready_q;
    assign buf_wr_en      = wr_en_q;
    assign buf_wr_bank    = wr_bank_q;
    assign buf_wr_addr    = wr_addr_q;
    assign buf_wr_data    = wr_data_q;
    assign bank_full      = bank_full_s;

endmodule

// File: tb/tb_weight_load_sched.sv
// Bench for weight_load_sched: table of layer configurations, hand-written
// bank-hold and reset-abort sequences, then randomized layers.
module tb_weight_load_sched;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 11;
    localparam int TILE_W = 8;

    logic              sclk = 1'b0;
    logic              s_rst;
    logic              cfg_start;
    logic [LEN_W-1:0]  cfg_len;
    logic [TILE_W-1:0] cfg_tiles;
    logic              busy, done, err_last;
    logic [DATA_W-1:0] s_weight_data;
    logic              s_weight_valid, s_weight_last, s_weight_ready;
    logic              buf_wr_en, buf_wr_bank;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [DATA_W-1:0] buf_wr_data;
    logic [1:0]        bank_full;
    logic [1:0]        bank_release;

    always #5 sclk = ~sclk;

    weight_load_sched dut (
        .sclk(sclk), .s_rst(s_rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .cfg_tiles(cfg_tiles), .busy(busy), .done(done), .err_last(err_last),
        .s_weight_data(s_weight_data), .s_weight_valid(s_weight_valid),
        .s_weight_last(s_weight_last), .s_weight_ready(s_weight_ready),
        .buf_wr_en(buf_wr_en), .buf_wr_bank(buf_wr_bank), .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data), .bank_full(bank_full), .bank_release(bank_release)
    );

    typedef struct {
        int len;
        int tiles;
        int gap;
        int err_beat;
        int exp_writes;
        bit exp_err;
    } vec_t;

    vec_t        tbl[8];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc;
    int          src_len, src_total, src_sent, src_err, src_gap;
    bit          hs_pend;
    int          done_cnt, done_cyc, first_ready;
    bit          rel_auto;
    logic [1:0]  man_rel;
    int          rd[2];
    int unsigned seed;
    logic [74:0] act_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] dat(input int g);
        return (64'(g) + 64'(seed)) * 64'h9E37_79B9_7F4A_7C15;
    endfunction

    // Expected write for global beat g: tile g/len goes to bank (tile mod 2), address g mod len.
    function automatic logic [74:0] exp_wr(input int g);
        int t;
        int b;
        t = g / src_len;
        b = g % src_len;
        return {1'(t % 2), 10'(b), dat(g)};
    endfunction

    function automatic logic [127:0] out_vec();
        return 128'({busy, done, err_last, s_weight_ready, buf_wr_en, buf_wr_bank,
                     buf_wr_addr, buf_wr_data, bank_full});
    endfunction

    task automatic src_setup(input int len, input int tiles, input int gap, input int err_beat);
        src_len   = len;
        src_total = (len > 0 && tiles > 0) ? len * tiles : 0;
        src_sent  = 0;
        src_err   = err_beat;
        src_gap   = gap;
        hs_pend   = 1'b0;
        done_cnt  = 0;
        done_cyc  = -1;
        first_ready = -1;
        man_rel   = 2'b00;
        rd[0]     = -1;
        rd[1]     = -1;
        act_q.delete();
        seed      = $urandom;
        cyc       = 0;
    endtask

    // One clock: capture bus writes, account handshakes, run engine and source.
    task automatic step();
        @(negedge sclk);
        cyc++;
        if (buf_wr_en) act_q.push_back({buf_wr_bank, buf_wr_addr, buf_wr_data});
        if (hs_pend) src_sent++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (s_weight_ready && first_ready < 0) first_ready = cyc;
        bank_release = man_rel;
        man_rel = 2'b00;
        if (rel_auto) begin
            for (int b = 0; b < 2; b++) begin
                if (rd[b] < 0) begin
                    if (bank_full[b]) rd[b] = $urandom_range(0, 6);
                end else if (rd[b] == 0) begin
                    bank_release[b] = 1'b1;
                    rd[b] = -1;
                end else begin
                    rd[b]--;
                end
            end
        end
        if (src_sent < src_total) begin
            s_weight_valid = ($urandom_range(0, 99) >= src_gap);
            s_weight_data  = dat(src_sent);
            s_weight_last  = ((src_sent % src_len) == (src_len - 1)) ^ (src_sent == src_err);
        end else begin
            s_weight_valid = 1'b0;
            s_weight_data  = 64'd0;
            s_weight_last  = 1'b0;
        end
        hs_pend = s_weight_valid && s_weight_ready;
    endtask

    task automatic run_layer(input int len, input int tiles, input int gap, input int err_beat,
                             input int exp_writes, input bit exp_err);
        int wr_idx;
        int full_bank;
        int full_at;
        int budget;
        logic [74:0] got;
        src_setup(len, tiles, gap, err_beat);
        rel_auto  = 1'b1;
        wr_idx    = 0;
        full_bank = 0;
        full_at   = -1;
        budget    = 100 + 5 * src_total + 30 * tiles;
        cfg_start = 1'b1;
        cfg_len   = LEN_W'(len);
        cfg_tiles = TILE_W'(tiles);
        while (1) begin
            step();
            if (cyc == 1) begin
                chk("busy_after_start", 128'(busy), 128'(1));
                chk("err_cleared_by_start", 128'(err_last), 128'(0));
                cfg_len   = 11'd3;
                cfg_tiles = 8'd1;
            end else begin
                cfg_start = 1'b0;
            end
            while (act_q.size() > 0) begin
                got = act_q.pop_front();
                if (wr_idx < src_total) begin
                    chk("write", 128'(got), 128'(exp_wr(wr_idx)));
                    if (int'(got[73:64]) == len - 1) begin
                        full_bank = int'(got[74]);
                        full_at   = cyc + 1;
                    end
                end else begin
                    chk("write_beyond_layer", 128'(wr_idx), 128'(src_total - 1));
                end
                wr_idx++;
            end
            if (full_at == cyc) chk("bank_full_after_tile", 128'(bank_full[full_bank]), 128'(1));
            if (s_weight_ready) chk("ready_only_when_busy", 128'(busy), 128'(1));
            if (done_cyc == cyc) chk("busy_low_at_done", 128'(busy), 128'(0));
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            if (cyc > budget) begin
                chk("layer_timeout", 128'(cyc), 128'(budget));
                break;
            end
        end
        chk("write_count", 128'(wr_idx), 128'(exp_writes));
        chk("done_pulses", 128'(done_cnt), 128'(1));
        chk("err_last", 128'(err_last), 128'(exp_err));
        chk("idle_outputs", 128'({busy, s_weight_ready, bank_full}), 128'(0));
        if (len == 0 || tiles == 0) begin
            chk("empty_done_cycle", 128'(done_cyc), 128'(2));
            chk("empty_never_ready", 128'(first_ready), 128'(-1));
        end else begin
            chk("ready_latency", 128'(first_ready), 128'(2));
        end
    endtask

    initial begin
        s_rst = 1'b1;
        cfg_start = 1'b0;
        cfg_len = 11'd0;
        cfg_tiles = 8'd0;
        s_weight_data = 64'd0;
        s_weight_valid = 1'b0;
        s_weight_last = 1'b0;
        bank_release = 2'b00;
        rel_auto = 1'b0;
        src_setup(1, 0, 0, -1);
        repeat (3) @(negedge sclk);
        chk("reset_outputs", out_vec(), 128'(0));
        s_rst = 1'b0;

        //            len  tiles gap err  writes err
        tbl[0] = '{1024, 1,   0,  -1, 1024, 1'b0};
        tbl[1] = '{16,   2,   40, -1, 32,   1'b0};
        tbl[2] = '{4,    1,   0,   2, 4,    1'b1};
        tbl[3] = '{4,    3,   20, -1, 12,   1'b0};
        tbl[4] = '{1,    5,   30, -1, 5,    1'b0};
        tbl[5] = '{7,    4,   10,  6, 28,   1'b1};
        tbl[6] = '{0,    3,   0,  -1, 0,    1'b0};
        tbl[7] = '{5,    0,   0,  -1, 0,    1'b0};
        for (int i = 0; i < 8; i++) begin
            run_layer(tbl[i].len, tbl[i].tiles, tbl[i].gap, tbl[i].err_beat,
                      tbl[i].exp_writes, tbl[i].exp_err);
            repeat (4) step();
            chk("err_last_sticky", 128'(err_last), 128'(tbl[i].exp_err));
        end

        // Bank hold: three tiles of 4 with the engine holding both banks.
        src_setup(4, 3, 0, -1);
        rel_auto = 1'b0;
        cfg_start = 1'b1;
        cfg_len = 11'd4;
        cfg_tiles = 8'd3;
        step();
        cfg_start = 1'b0;
        while (bank_full != 2'b11 && cyc < 100) step();
        chk("hold_both_full", 128'(bank_full), 128'(2'b11));
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold_ready_low", 128'(s_weight_ready), 128'(0));
        end
        chk("hold_first_writes", 128'(act_q.size()), 128'(8));
        for (int g = 0; g < 8 && act_q.size() > 0; g++) chk("hold_write", 128'(act_q.pop_front()), 128'(exp_wr(g)));
        man_rel = 2'b01;
        while (act_q.size() < 4 && cyc < 200) step();
        for (int g = 8; g < 12 && act_q.size() > 0; g++) chk("hold_tile3_write", 128'(act_q.pop_front()), 128'(exp_wr(g)));
        repeat (3) step();
        chk("hold_refull", 128'(bank_full), 128'(2'b11));
        chk("hold_no_early_done", 128'(done_cnt), 128'(0));
        man_rel = 2'b11;
        while (done_cnt == 0 && cyc < 300) step();
        chk("hold_done", 128'({done_cnt, 1'(busy)}), 128'({32'd1, 1'b0}));
        repeat (3) step();

        // Reset abort in the middle of a tile, then a clean restart from bank 0.
        src_setup(8, 2, 0, -1);
        rel_auto = 1'b1;
        cfg_start = 1'b1;
        cfg_len = 11'd8;
        cfg_tiles = 8'd2;
        step();
        cfg_start = 1'b0;
        while (src_sent < 5 && cyc < 50) step();
        chk("abort_mid_load", 128'(s_weight_ready), 128'(1));
        s_rst = 1'b1;
        #1;
        chk("abort_outputs_zero", out_vec(), 128'(0));
        src_total = 0;
        step();
        chk("abort_held_zero", out_vec(), 128'(0));
        s_rst = 1'b0;
        step();
        run_layer(4, 2, 0, -1, 8, 1'b0);
        repeat (2) step();

        // Randomized layers against the framing model.
        for (int i = 0; i < 6; i++) begin
            int len;
            int tiles;
            int eb;
            len   = $urandom_range(1, 40);
            tiles = $urandom_range(1, 6);
            eb    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len * tiles - 1)) : -1;
            run_layer(len, tiles, $urandom_range(0, 60), eb, len * tiles, eb >= 0);
            repeat (2) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
